// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the subsystems it releases.
// The master side is the sequencer; the slave side is the set of stages.
interface reset_sequencer_if #(
  parameter int unsigned Stages = 4
);
  localparam int unsigned IdxW = (Stages > 1) ? $clog2(Stages) : 1;

  logic              req_restart;
  logic [Stages-1:0] stage_ready;
  logic [Stages-1:0] stage_en;
  logic              all_up;
  logic              fault;
  logic [IdxW-1:0]   fault_stage;

  modport master (
    input  req_restart,
    input  stage_ready,
    output stage_en,
    output all_up,
    output fault,
    output fault_stage
  );

  modport slave (
    output req_restart,
    output stage_ready,
    input  stage_en,
    input  all_up,
    input  fault,
    input  fault_stage
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases downstream stages one at a time after global reset, with a settling delay
// before each enable and a ready timeout that latches a fault.
module reset_sequencer #(
  parameter int unsigned Stages     = 4,
  parameter int unsigned StageDelay = 16,
  parameter int unsigned Timeout    = 256,
  parameter int unsigned SyncStages = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  reset_sequencer_if.master  bus
);

  localparam int unsigned IdxW   = (Stages > 1) ? $clog2(Stages) : 1;
  localparam int unsigned CntMax = (StageDelay > Timeout) ? StageDelay : Timeout;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {StHold, StDelay, StWaitRdy, StUp, StFault} state_e;

  logic [SyncStages-1:0] sync_q;
  logic                  rst_sync;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Stages-1:0] stage_en_q, stage_en_d;
  logic              all_up_q, all_up_d;
  logic              fault_q, fault_d;
  logic [IdxW-1:0]   fault_stage_q, fault_stage_d;

  // Assertion is asynchronous, release is synchronised to clk_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StHold;
      idx_q         <= '0;
      cnt_q         <= '0;
      stage_en_q    <= '0;
      all_up_q      <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      stage_en_q    <= stage_en_d;
      all_up_q      <= all_up_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (rst_sync) begin
      if (bus.req_restart && (state_q != StHold)) begin
        state_d = StHold;
        idx_d   = '0;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          StHold: begin
            state_d = StDelay;
            idx_d   = '0;
            cnt_d   = '0;
          end
          StDelay: begin
            if (cnt_q == CntW'(StageDelay - 1)) begin
              state_d = StWaitRdy;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          StWaitRdy: begin
            // Ready is checked before the timeout so a last-cycle ready still succeeds.
            if (bus.stage_ready[idx_q]) begin
              cnt_d = '0;
              if (idx_q == IdxW'(Stages - 1)) begin
                state_d = StUp;
              end else begin
                state_d = StDelay;
                idx_d   = idx_q + IdxW'(1);
              end
            end else if (cnt_q == CntW'(Timeout - 1)) begin
              state_d = StFault;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          StUp:    ;
          StFault: ;
          default: state_d = StHold;
        endcase
      end
    end
  end

  // Outputs are decoded from the next state so they leave the flops already aligned.
  always_comb begin
    stage_en_d    = '0;
    all_up_d      = 1'b0;
    fault_d       = 1'b0;
    fault_stage_d = '0;
    unique case (state_d)
      StDelay: begin
        for (int i = 0; i < int'(Stages); i++) begin
          stage_en_d[i] = (i < int'(idx_d));
        end
      end
      StWaitRdy: begin
        for (int i = 0; i < int'(Stages); i++) begin
          stage_en_d[i] = (i <= int'(idx_d));
        end
      end
      StUp: begin
        stage_en_d = '1;
        all_up_d   = 1'b1;
      end
      StFault: begin
        fault_d       = 1'b1;
        fault_stage_d = idx_d;
      end
      default: ;
    endcase
  end

  assign bus.stage_en    = stage_en_q;
  assign bus.all_up      = all_up_q;
  assign bus.fault       = fault_q;
  assign bus.fault_stage = fault_stage_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the design's active-low global enable and releases the downstream subsystems one at a time, in a fixed order. After the global enable deasserts reset, the block walks the stages in ascending order. For each stage it waits a programmable settling delay, asserts that stage's enable, then waits for the stage's ready handshake before moving on. A missing ready drops every stage and latches a fault. A soft restart request re-runs the whole sequence without a global reset.

## Interface
- STAGES, 4, number of sequenced subsystems (2..16).
- STAGE_DELAY, 16, clocks between entering a stage's delay and asserting its enable (≥1).
- TIMEOUT, 256, clocks allowed for stage_ready after stage_en rises (≥1).
- SYNC_STAGES, 2, flops in the reset-release synchronizer (≥2).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (low = held in reset); driven by the global enable generator.
- req_restart  in  1  single-cycle soft restart request, synchronous to clk.
- stage_ready  in  STAGES  per-stage ready, synchronous to clk; bit i is valid only while stage_en[i]=1.
- stage_en  out  STAGES  per-stage enable, registered.
- all_up  out  1  high when every stage is enabled and has reported ready.
- fault  out  1  latched timeout indication.
- fault_stage  out  max(1,$clog2(STAGES))  index of the stage that timed out.

## Operation
- Reset synchronizer
  - rst low clears the SYNC_STAGES-flop chain asynchronously.
  - On release, the chain shifts in 1s; its last flop is rst_sync.
  - All other state is asynchronously reset by rst; logic advances only while rst_sync=1.
- Reset values: stage_en=0, all_up=0, fault=0, fault_stage=0, state=HOLD, idx=0, cnt=0.
- States:
  - HOLD: waits for rst_sync=1. Next edge: idx=0, cnt=0, go to DELAY.
  - DELAY: cnt increments each cycle. When cnt==STAGE_DELAY-1, the next edge sets stage_en[idx]=1, cnt=0, go to WAIT_RDY.
  - WAIT_RDY: samples stage_ready[idx] each cycle.
    - Ready=1 and idx<STAGES-1: idx++, cnt=0, go to DELAY.
    - Ready=1 and idx==STAGES-1: go to UP.
    - Ready=0: cnt increments. When cnt==TIMEOUT-1 with ready still 0, go to FAULT.
    - Ready=1 on the final timeout cycle counts as success (ready wins).
  - UP: all_up=1 and stage_en all ones. Holds indefinitely; ready drops here are ignored.
  - FAULT: stage_en=0, all_up=0, fault=1, fault_stage=idx; all latched until restart.
- req_restart
  - In DELAY, WAIT_RDY, UP or FAULT: next edge clears stage_en, all_up, fault, fault_stage, idx and cnt, and enters HOLD. With rst_sync=1 the sequence then restarts.
  - Has priority over ready and timeout in the same cycle.
  - Ignored in HOLD.
- rst asserted in any state, mid-sequence included: all outputs clear immediately (asynchronously), with no wait for clk.
- Stages already enabled stay enabled while later stages sequence. Only FAULT, restart or reset clears them.
- Counters are sized for max(STAGE_DELAY, TIMEOUT) and never wrap; they are cleared on every state entry.

## Timing
- Reset release to rst_sync=1: SYNC_STAGES rising edges.
- rst_sync=1 to leaving HOLD: 1 edge.
- DELAY entry to stage_en[idx] rising: STAGE_DELAY edges.
- Ready already high when the stage enables:
  - stage_en[i] to stage_en[i+1]: STAGE_DELAY+1 edges.
  - stage_en[STAGES-1] to all_up: 1 edge.
- Ready never arrives: stage_en[idx] rising to fault=1 is TIMEOUT edges. stage_en clears on that same edge.
- req_restart sampled high: outputs clear on the next edge. The next stage_en[0] rises STAGE_DELAY+1 edges after that.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench parameters: STAGES=3, STAGE_DELAY=4, TIMEOUT=8, SYNC_STAGES=2.
- Ready tied high, release rst at edge 0 → rst_sync=1 after edge 2, HOLD exits at edge 3, stage_en=001 at edge 7, 011 at 12, 111 at 17, all_up=1 at 18.
- stage_ready[1] held low forever → stage_en=011 at edge 12, then at edge 20 fault=1, fault_stage=1, stage_en=000, all_up=0; stays latched for 50 cycles.
- stage_ready[1] rises in the last timeout cycle, cnt==7 → no fault; stage_en=111 five edges later.
- In FAULT, req_restart pulse → next edge fault=0 and stage_en=000; with ready high, stage_en=001 five edges later and the full sequence completes to all_up=1.
- rst driven low asynchronously between edges while stage_en=011 → stage_en=000 immediately, before the next edge. On release, the sequence repeats with the timing of scenario 1.
- In UP, req_restart asserted in the same cycle ready drops → restart wins: stage_en=000, all_up=0 next edge, and no fault.
